// File: rtl/uncached_dbus_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module   : uncached_dbus_bridge_if
//  Purpose  : dbus request/response and cbus request/response bundle for the
//             uncached data bridge.
//  Revision : 1.0 - initial release
// ============================================================================
interface uncached_dbus_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  dreq_valid;
    logic                  dreq_is_write;
    logic [ADDR_W-1:0]     dreq_addr;
    logic [DATA_W/8-1:0]   dreq_strobe;
    logic [DATA_W-1:0]     dreq_data;
    logic                  dresp_addr_ok;
    logic                  dresp_data_ok;
    logic [DATA_W-1:0]     dresp_data;
    logic                  creq_valid;
    logic                  creq_is_write;
    logic [ADDR_W-1:0]     creq_addr;
    logic [DATA_W/8-1:0]   creq_strobe;
    logic [DATA_W-1:0]     creq_data;
    logic [2:0]            creq_size;
    logic [3:0]            creq_len;
    logic                  cresp_ready;
    logic                  cresp_last;
    logic [DATA_W-1:0]     cresp_data;

    // The bridge itself: responder on dbus, requester on cbus.
    modport slave (
        input  dreq_valid, dreq_is_write, dreq_addr, dreq_strobe, dreq_data,
        output dresp_addr_ok, dresp_data_ok, dresp_data,
        output creq_valid, creq_is_write, creq_addr, creq_strobe, creq_data,
        output creq_size, creq_len,
        input  cresp_ready, cresp_last, cresp_data
    );

    // The surrounding environment (translation unit plus cbus arbiter).
    modport master (
        output dreq_valid, dreq_is_write, dreq_addr, dreq_strobe, dreq_data,
        input  dresp_addr_ok, dresp_data_ok, dresp_data,
        input  creq_valid, creq_is_write, creq_addr, creq_strobe, creq_data,
        input  creq_size, creq_len,
        output cresp_ready, cresp_last, cresp_data
    );
endinterface
`default_nettype wire

// File: rtl/uncached_dbus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : uncached_dbus_bridge
//  Purpose  : Replays one uncached dbus request at a time as a single-beat
//             cbus transaction. Optional macro UNCACHED_STORE_BUFFER_EN posts
//             stores (early data_ok, completion drains without a response).
//  Revision : 1.0 - initial release
// ============================================================================
module uncached_dbus_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    uncached_dbus_bridge_if.slave   bus
);
    localparam int         c_STRB_W   = DATA_W / 8;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic                r_is_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_STRB_W-1:0] r_strobe;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_accept;
    logic                w_done;

    assign w_accept = (r_state == c_ST_IDLE) && bus.dreq_valid;
    assign w_done   = (r_state == c_ST_ISSUE) && bus.cresp_ready && bus.cresp_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept) w_next_state = c_ST_ISSUE;
            c_ST_ISSUE: begin
                if (w_done) begin
`ifdef UNCACHED_STORE_BUFFER_EN
                    // Posted stores were already acknowledged; just drain.
                    w_next_state = r_is_write ? c_ST_IDLE : c_ST_RESP;
`else
                    w_next_state = c_ST_RESP;
`endif
                end
            end
            c_ST_RESP:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

`ifdef UNCACHED_STORE_BUFFER_EN
    logic r_issue_first;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_issue_first <= 1'b0;
        else         r_issue_first <= w_accept;
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_strobe   <= '0;
            r_data     <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_is_write <= bus.dreq_is_write;
                r_addr     <= bus.dreq_addr;
                r_strobe   <= bus.dreq_strobe;
                r_data     <= bus.dreq_data;
            end
            if (w_done) r_rdata <= r_is_write ? '0 : bus.cresp_data;
        end
    end

    always_comb begin
        bus.dresp_addr_ok = (r_state == c_ST_IDLE) && bus.dreq_valid;
        bus.creq_valid    = (r_state == c_ST_ISSUE);
        bus.dresp_data_ok = (r_state == c_ST_RESP);
`ifdef UNCACHED_STORE_BUFFER_EN
        if ((r_state == c_ST_ISSUE) && r_issue_first && r_is_write)
            bus.dresp_data_ok = 1'b1;
`endif
    end

    assign bus.dresp_data    = r_rdata;
    assign bus.creq_is_write = r_is_write;
    assign bus.creq_addr     = r_addr;
    assign bus.creq_strobe   = r_strobe;
    assign bus.creq_data     = r_data;
    assign bus.creq_size     = 3'b010;
    assign bus.creq_len      = 4'b0000;
endmodule
`default_nettype wire

// File: tb/tb_uncached_dbus_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uncached_dbus_bridge
//  Purpose  : Scoreboard bench for uncached_dbus_bridge (directed + random).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uncached_dbus_bridge;
`ifdef UNCACHED_STORE_BUFFER_EN
    localparam bit c_SB = 1'b1;
`else
    localparam bit c_SB = 1'b0;
`endif

    typedef struct {
        bit          w;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } req_t;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } resp_t;

    logic  clk = 1'b0;
    logic  resetn = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    req_t  req_q[$];
    resp_t resp_q[$];

    uncached_dbus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    uncached_dbus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    int   cyc = 0;
    bit   m_busy = 0;
    int   m_free_at = 0;
    bit   m_issuing = 0;
    int   m_issue_from = 0;
    req_t m_cur;
    int   dok_q[$];

    always @(negedge clk) begin
        bit    exp_aok, exp_cv;
        resp_t r;
        cyc++;
        if (!resetn) begin
            chk("rst_addr_ok", bus.dresp_addr_ok, 0);
            chk("rst_data_ok", bus.dresp_data_ok, 0);
            chk("rst_creq_valid", bus.creq_valid, 0);
            chk("rst_dresp_data", bus.dresp_data, 0);
            m_busy = 0; m_issuing = 0; dok_q.delete();
        end else begin
            if (m_busy && cyc >= m_free_at) m_busy = 0;
            exp_aok = bus.dreq_valid && !m_busy;
            exp_cv  = m_issuing && cyc >= m_issue_from;
            chk("addr_ok", bus.dresp_addr_ok, exp_aok);
            chk("creq_valid", bus.creq_valid, exp_cv);
            if (exp_cv) begin
                chk("creq_is_write", bus.creq_is_write, m_cur.w);
                chk("creq_addr", bus.creq_addr, m_cur.addr);
                chk("creq_strobe", bus.creq_strobe, m_cur.strb);
                chk("creq_data", bus.creq_data, m_cur.data);
                chk("creq_size", bus.creq_size, 3'b010);
                chk("creq_len", bus.creq_len, 4'b0000);
            end
            if (dok_q.size() > 0 && dok_q[0] == cyc) begin
                void'(dok_q.pop_front());
                chk("data_ok", bus.dresp_data_ok, 1);
                if (resp_q.size() == 0) chk("resp_q_nonempty", 0, 1);
                else begin
                    r = resp_q.pop_front();
                    if (r.chk) chk("dresp_data", bus.dresp_data, r.data);
                end
            end else begin
                chk("data_ok", bus.dresp_data_ok, 0);
            end
            if (exp_aok) begin
                if (req_q.size() == 0) chk("req_q_nonempty", 0, 1);
                else m_cur = req_q.pop_front();
                m_busy = 1; m_free_at = 32'h7fff_ffff;
                m_issuing = 1; m_issue_from = cyc + 1;
                if (c_SB && m_cur.w) dok_q.push_back(cyc + 1);
            end
            if (exp_cv && bus.cresp_ready && bus.cresp_last) begin
                m_issuing = 0;
                if (c_SB && m_cur.w) m_free_at = cyc + 1;
                else begin
                    dok_q.push_back(cyc + 1);
                    m_free_at = cyc + 2;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input bit w, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data);
        resp_t r;
        bus.dreq_valid = 1; bus.dreq_is_write = w; bus.dreq_addr = addr;
        bus.dreq_strobe = strb; bus.dreq_data = data;
        req_q.push_back('{w: w, addr: addr, strb: strb, data: data});
    endtask

    task automatic wait_accept(input bit keep_valid);
        int t = 0;
        forever begin
            @(negedge clk);
            if (bus.dresp_addr_ok) break;
            if (++t > 50) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        tick();
        if (!keep_valid) begin
            bus.dreq_valid = 0;
            bus.dreq_addr = $urandom; bus.dreq_data = $urandom;
        end
    endtask

    task automatic txn(input bit w, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] data, input logic [31:0] rd,
                       input int gap, input int nonlast, input bit keep_valid);
        send(w, addr, strb, data);
        resp_q.push_back('{chk: !(c_SB && w), data: w ? 32'h0 : rd});
        wait_accept(keep_valid);
        for (int i = 0; i < gap; i++) begin
            bus.cresp_ready = 0; bus.cresp_last = 1'($urandom); bus.cresp_data = $urandom;
            tick();
        end
        for (int i = 0; i < nonlast; i++) begin
            bus.cresp_ready = 1; bus.cresp_last = 0; bus.cresp_data = $urandom;
            tick();
        end
        bus.cresp_ready = 1; bus.cresp_last = 1; bus.cresp_data = rd;
        tick();
        bus.cresp_ready = 0; bus.cresp_last = 0; bus.cresp_data = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        bus.dreq_valid = 0; bus.dreq_is_write = 0; bus.dreq_addr = 0;
        bus.dreq_strobe = 0; bus.dreq_data = 0;
        bus.cresp_ready = 0; bus.cresp_last = 0; bus.cresp_data = 0;
        repeat (3) tick();
        resetn = 1;
        tick();

        // Load with completion in the third creq_valid cycle.
        txn(0, 32'h1FC0_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 2, 0, 0);
        tick(); tick();
        // Store, immediate completion.
        txn(1, 32'h1FAF_0010, 4'b0011, 32'h1234_5678, 32'hCAFE_0000, 0, 0, 0);
        tick();
        // Two loads with dreq_valid held high throughout.
        txn(0, 32'h1000_0004, 4'hF, 32'h0, 32'h1111_2222, 0, 0, 1);
        txn(0, 32'h1000_0008, 4'hF, 32'h0, 32'h3333_4444, 1, 0, 0);
        tick();
        // Non-last beats are ignored.
        txn(0, 32'h1000_000C, 4'hF, 32'h0, 32'h5555_6666, 0, 2, 0);
        tick();
        // Zero-strobe store is still issued.
        txn(1, 32'h1000_0010, 4'b0000, 32'hA5A5_A5A5, 32'h0, 1, 0, 0);
        tick();

        // Reset while the request is in ISSUE.
        send(0, 32'h2000_0000, 4'hF, 32'h0);
        wait_accept(0);
        tick();
        #2 resetn = 0;
        tick();
        resetn = 1;
        tick();
        txn(0, 32'h2000_0004, 4'hF, 32'h0, 32'h7777_8888, 1, 0, 0);
        tick();

        // Store followed by a load with valid held high.
        txn(1, 32'h3000_0000, 4'hF, 32'hBEEF_0001, 32'h0, 2, 0, 1);
        txn(0, 32'h3000_0004, 4'hF, 32'h0, 32'h9999_AAAA, 0, 0, 0);
        tick();

        for (int n = 0; n < 150; n++) begin
            bit w = 1'($urandom);
            txn(w, $urandom, ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom),
                $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                bus.dreq_valid = 0;
                tick();
            end
        end
        bus.dreq_valid = 0;

        t = 0;
        while (resp_q.size() != 0 && t < 20) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk("resp_q_drained", resp_q.size(), 0);
        chk("req_q_drained", req_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
